// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand interface: field widths, func codes
// and the packed operation tuple carried between host, FIFO and ALU.
package alu_pkg;

    localparam int REG_W  = 4;
    localparam int FUNC_W = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int OP_W   = 3 * REG_W + FUNC_W + ADDR_W;

    typedef enum logic [FUNC_W-1:0] {
        FUNC_ADD   = 4'd0,
        FUNC_SUB   = 4'd1,
        FUNC_MUL   = 4'd2,
        FUNC_PASSA = 4'd3,
        FUNC_PASSB = 4'd4,
        FUNC_AND   = 4'd5,
        FUNC_OR    = 4'd6,
        FUNC_XOR   = 4'd7,
        FUNC_NOTA  = 4'd8,
        FUNC_SHL   = 4'd9,
        FUNC_SHR   = 4'd10,
        FUNC_SLA   = 4'd11
    } alu_func_e;

    // func kept as raw bits so unlisted codes pass through untouched
    typedef struct packed {
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [FUNC_W-1:0] func;
        logic [ADDR_W-1:0] addr;
    } op_t;

endpackage

// File: rtl/alu_op_fifo.sv
// Synchronous DEPTH-entry FIFO of op tuples; wrap-bit pointers, no fall-through,
// flush empties it and drops any same-cycle push.
module alu_op_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  op_t  wdata,
    output op_t  rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    op_t         mem_r [DEPTH];
    logic        do_push_s;
    logic        do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; flush resets both pointers so a simultaneous push is lost
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Issues buffered op tuples to a free-running ALU pipeline, one per cycle,
// inserting idempotent bubble ops while a RAW hazard against in-flight ops exists.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int LAT         = 3,
    parameter int BUBBLE_REG  = 0,
    parameter int BUBBLE_ADDR = 255,
    parameter int NOP_FUNC    = 3
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [FUNC_W-1:0] in_func,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              flush,
    output logic [REG_W-1:0]  rs1,
    output logic [REG_W-1:0]  rs2,
    output logic [REG_W-1:0]  rd,
    output logic [FUNC_W-1:0] func,
    output logic [ADDR_W-1:0] addr,
    output logic              out_valid,
    output logic              busy,
    output logic [15:0]       stall_cnt
);

    // LAT=1 keeps one dummy slot that is never loaded, so no hazard can arise
    localparam int  SB_N  = (LAT > 1) ? LAT - 1 : 1;
    localparam bit  SB_EN = (LAT > 1);
    localparam op_t BUBBLE_OP = '{
        rs1:  REG_W'(BUBBLE_REG),
        rs2:  REG_W'(BUBBLE_REG),
        rd:   REG_W'(BUBBLE_REG),
        func: FUNC_W'(NOP_FUNC),
        addr: ADDR_W'(BUBBLE_ADDR)
    };

    op_t                         push_op_s;
    op_t                         head_s;
    logic                        full_s;
    logic                        empty_s;
    logic                        push_s;
    logic                        hazard_s;
    logic                        issue_s;
    logic [SB_N-1:0]             sb_valid_r;
    logic [SB_N-1:0][REG_W-1:0]  sb_rd_r;
    op_t                         out_r;
    logic                        out_valid_r;
    logic [15:0]                 stall_cnt_r;

    assign push_op_s = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};
    assign in_ready  = !rst && !full_s;
    assign push_s    = in_valid && in_ready;
    assign issue_s   = !empty_s && !hazard_s && !flush && !rst;

    alu_op_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk1),
        .rst   (rst),
        .push  (push_s),
        .pop   (issue_s),
        .flush (flush),
        .wdata (push_op_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // RAW check of the head sources against every in-flight destination
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < SB_N; i++) begin
            if (sb_valid_r[i] && (sb_rd_r[i] == head_s.rs1 || sb_rd_r[i] == head_s.rs2)) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    // Scoreboard shift register; keeps moving through flushes and stalls
    always_ff @(posedge clk1) begin
        if (rst) begin
            sb_valid_r <= '0;
            sb_rd_r    <= '0;
        end else begin
            for (int i = SB_N - 1; i > 0; i--) begin
                sb_valid_r[i] <= sb_valid_r[i-1];
                sb_rd_r[i]    <= sb_rd_r[i-1];
            end
            sb_valid_r[0] <= issue_s && SB_EN;
            sb_rd_r[0]    <= head_s.rd;
        end
    end

    // Registered operand bus and stall counter
    always_ff @(posedge clk1) begin
        if (rst) begin
            out_r       <= BUBBLE_OP;
            out_valid_r <= 1'b0;
            stall_cnt_r <= 16'd0;
        end else if (issue_s) begin
            out_r       <= head_s;
            out_valid_r <= 1'b1;
        end else begin
            out_r       <= BUBBLE_OP;
            out_valid_r <= 1'b0;
            if (!empty_s && !flush) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end
        end
    end

    assign rs1       = out_r.rs1;
    assign rs2       = out_r.rs2;
    assign rd        = out_r.rd;
    assign func      = out_r.func;
    assign addr      = out_r.addr;
    assign out_valid = out_valid_r;
    assign stall_cnt = stall_cnt_r;
    assign busy      = !empty_s || (|sb_valid_r);

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer at default parameters (DEPTH=8, LAT=3).
module tb_alu_op_issuer;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  in_rs1 = 4'd0, in_rs2 = 4'd0, in_rd = 4'd0, in_func = 4'd0;
    logic [7:0]  in_addr = 8'd0;
    logic        in_ready, out_valid, busy;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr;
    logic [15:0] stall_cnt;
    logic [23:0] out_op;

    int total = 0;
    int bad = 0;
    int exp_stall = 0;

    localparam logic [23:0] BUB   = {4'd0, 4'd0, 4'd0, 4'd3, 8'd255};
    localparam logic [23:0] OP_A  = {4'd3, 4'd5, 4'd10, 4'd0, 8'd125};
    localparam logic [23:0] OP_B  = {4'd3, 4'd8, 4'd12, 4'd2, 8'd126};
    localparam logic [23:0] OP_C  = {4'd10, 4'd5, 4'd14, 4'd1, 8'd128};
    localparam logic [23:0] OP_D  = {4'd7, 4'd3, 4'd13, 4'd11, 8'd127};
    localparam logic [23:0] OP_E  = {4'd13, 4'd13, 4'd15, 4'd0, 8'd130};

    alu_op_issuer dut (
        .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
        .flush(flush), .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
        .out_valid(out_valid), .busy(busy), .stall_cnt(stall_cnt)
    );

    always #5 clk1 = ~clk1;
    assign out_op = {rs1, rs2, rd, func, addr};

    task automatic tick;
        @(posedge clk1);
        #1;
    endtask

    task automatic drive(input logic [23:0] op);
        {in_rs1, in_rs2, in_rd, in_func, in_addr} = op;
        in_valid = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive({4'd1, 4'd2, 4'd3, 4'd0, 8'd9});
        for (int c = 0; c < 3; c++) begin
            tick;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready c=%0d got=%b want=0", c, in_ready); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid c=%0d got=%b want=0", c, out_valid); end
            total++; if (out_op !== BUB) begin bad++; $display("FAIL reset_outputs c=%0d got=%h want=%h", c, out_op, BUB); end
            total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall c=%0d got=%0d want=0", c, stall_cnt); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy c=%0d got=%b want=0", c, busy); end
        end
        in_valid = 1'b0;
        rst = 1'b0;
        tick;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle got=%b%b want=00", out_valid, busy); end
    endtask

    task automatic test_independent;
        drive(OP_A); tick;
        drive(OP_B); tick;
        total++; if (out_valid !== 1'b1 || out_op !== OP_A) begin bad++; $display("FAIL indep_op1 got=%b/%h want=1/%h", out_valid, out_op, OP_A); end
        in_valid = 1'b0; tick;
        total++; if (out_valid !== 1'b1 || out_op !== OP_B) begin bad++; $display("FAIL indep_op2 got=%b/%h want=1/%h", out_valid, out_op, OP_B); end
        tick;
        total++; if (out_valid !== 1'b0 || out_op !== BUB) begin bad++; $display("FAIL indep_idle got=%b/%h want=0/%h", out_valid, out_op, BUB); end
        total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL indep_stall got=%0d want=%0d", stall_cnt, exp_stall); end
        repeat (3) tick;
    endtask

    task automatic test_raw;
        drive(OP_A); tick;
        drive(OP_B); tick;
        total++; if (out_valid !== 1'b1 || out_op !== OP_A) begin bad++; $display("FAIL raw_op1 got=%b/%h want=1/%h", out_valid, out_op, OP_A); end
        drive(OP_C); tick;
        total++; if (out_valid !== 1'b1 || out_op !== OP_B) begin bad++; $display("FAIL raw_op2 got=%b/%h want=1/%h", out_valid, out_op, OP_B); end
        in_valid = 1'b0; tick;
        exp_stall = 1;
        total++; if (out_valid !== 1'b0 || out_op !== BUB) begin bad++; $display("FAIL raw_bubble got=%b/%h want=0/%h", out_valid, out_op, BUB); end
        total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL raw_stall got=%0d want=%0d", stall_cnt, exp_stall); end
        tick;
        total++; if (out_valid !== 1'b1 || out_op !== OP_C) begin bad++; $display("FAIL raw_op3 got=%b/%h want=1/%h", out_valid, out_op, OP_C); end
        repeat (3) tick;
    endtask

    task automatic test_back_to_back;
        drive(OP_D); tick;
        drive(OP_E); tick;
        total++; if (out_valid !== 1'b1 || out_op !== OP_D) begin bad++; $display("FAIL b2b_first got=%b/%h want=1/%h", out_valid, out_op, OP_D); end
        in_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            tick;
            total++; if (out_valid !== 1'b0 || out_op !== BUB) begin bad++; $display("FAIL b2b_bubble%0d got=%b/%h want=0/%h", b, out_valid, out_op, BUB); end
        end
        exp_stall = 3;
        total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL b2b_stall got=%0d want=%0d", stall_cnt, exp_stall); end
        tick;
        total++; if (out_valid !== 1'b1 || out_op !== OP_E) begin bad++; $display("FAIL b2b_second got=%b/%h want=1/%h", out_valid, out_op, OP_E); end
        repeat (3) tick;
    endtask

    // Chain op k reads rd of op k-1, so issue happens every third edge: 2+3k
    task automatic test_full;
        logic [23:0] exp_op;
        logic        exp_v;
        logic        exp_rdy;
        int          k;
        for (int n = 1; n <= 38; n++) begin
            if (n <= 12) drive({4'(n - 1), 4'(n - 1), 4'(n), 4'd0, 8'(15 + n)});
            else if (n == 13) drive({4'd12, 4'd12, 4'd13, 4'd0, 8'd28});
            else in_valid = 1'b0;
            tick;
            exp_rdy = !(n == 12 || n == 13);
            k = (n - 2) / 3;
            exp_v = (n >= 2) && ((n - 2) % 3 == 0) && (k <= 11);
            exp_op = exp_v ? {4'(k), 4'(k), 4'(k + 1), 4'd0, 8'(16 + k)} : BUB;
            total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL full_in_ready n=%0d got=%b want=%b", n, in_ready, exp_rdy); end
            total++; if (out_valid !== exp_v || out_op !== exp_op) begin bad++; $display("FAIL full_issue n=%0d got=%b/%h want=%b/%h", n, out_valid, out_op, exp_v, exp_op); end
        end
        exp_stall = 25;
        total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL full_stall got=%0d want=%0d", stall_cnt, exp_stall); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_flush;
        logic [23:0] ops   [6];
        logic [23:0] exp_o [6];
        logic        exp_v [6];
        ops[0] = {4'd0, 4'd0, 4'd4, 4'd0, 8'd40};
        ops[1] = {4'd4, 4'd0, 4'd9, 4'd0, 8'd41};
        ops[2] = {4'd9, 4'd0, 4'd5, 4'd0, 8'd50};
        ops[3] = {4'd1, 4'd1, 4'd6, 4'd0, 8'd51};
        ops[4] = {4'd1, 4'd1, 4'd7, 4'd0, 8'd52};
        ops[5] = {4'd1, 4'd1, 4'd8, 4'd0, 8'd53};
        exp_o[0] = BUB; exp_o[1] = ops[0]; exp_o[2] = BUB; exp_o[3] = BUB; exp_o[4] = ops[1]; exp_o[5] = BUB;
        exp_v[0] = 1'b0; exp_v[1] = 1'b1; exp_v[2] = 1'b0; exp_v[3] = 1'b0; exp_v[4] = 1'b1; exp_v[5] = 1'b0;
        for (int n = 0; n < 6; n++) begin
            drive(ops[n]); tick;
            total++; if (out_valid !== exp_v[n] || out_op !== exp_o[n]) begin bad++; $display("FAIL flush_pre n=%0d got=%b/%h want=%b/%h", n, out_valid, out_op, exp_v[n], exp_o[n]); end
        end
        exp_stall = 28;
        total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL flush_pre_stall got=%0d want=%0d", stall_cnt, exp_stall); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_pre_busy got=%b want=1", busy); end
        drive({4'd1, 4'd1, 4'd11, 4'd0, 8'd54});
        flush = 1'b1; tick;
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || out_op !== BUB) begin bad++; $display("FAIL flush_edge got=%b/%h want=0/%h", out_valid, out_op, BUB); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", busy); end
        for (int c = 0; c < 6; c++) begin
            tick;
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_after c=%0d got=%b%b want=01", c, out_valid, in_ready); end
        end
    endtask

    task automatic test_reset_mid;
        drive(OP_A); tick;
        drive({4'd10, 4'd10, 4'd1, 4'd0, 8'd60}); tick;
        total++; if (out_valid !== 1'b1 || out_op !== OP_A) begin bad++; $display("FAIL rstmid_issue got=%b/%h want=1/%h", out_valid, out_op, OP_A); end
        in_valid = 1'b0;
        rst = 1'b1; tick;
        exp_stall = 0;
        total++; if (out_valid !== 1'b0 || out_op !== BUB || busy !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_state got=%b/%h/%b/%b want=0/%h/0/0", out_valid, out_op, busy, in_ready, BUB); end
        total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL rstmid_stall got=%0d want=%0d", stall_cnt, exp_stall); end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_issue c=%0d got=%b want=0", c, out_valid); end
        end
    endtask

    initial begin
        test_reset;
        test_independent;
        test_raw;
        test_back_to_back;
        test_full;
        test_flush;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
